// File: rtl/lc3_display_pkg.sv
// lc3_display_pkg: shared types and constants for the LC-3 display controller
package lc3_display_pkg;
  localparam int CHAR_W    = 8;
  localparam int READY_BIT = 15;
  localparam int IE_BIT    = 14;
  localparam int OVF_BIT   = 13;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;
endpackage

// File: rtl/lc3_char_fifo.sv
// lc3_char_fifo: single-clock character FIFO with combinational head output
module lc3_char_fifo
  import lc3_display_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [CHAR_W-1:0]        din,
  output logic [CHAR_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [CHAR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign full    = count_q == (AW+1)'(DEPTH);
  assign empty   = count_q == '0;
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // storage needs no reset: entries are only read once counted valid
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_ptr_q] <= din;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(do_push);
      rd_ptr_q <= rd_ptr_q + AW'(do_pop);
      count_q  <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/lc3_display_ctrl.sv
// lc3_display_ctrl: DSR/DDR display controller draining a FIFO to a valid/ready sink
module lc3_display_ctrl
  import lc3_display_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int CHAR_GAP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              LD_DDR,
  input  logic              LD_DSR,
  input  logic [15:0]       DATA,
  output logic [15:0]       DSR,
  output logic [CHAR_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = CHAR_GAP > 1 ? $clog2(CHAR_GAP) : 1;
  state_e state_q, state_d;
  logic [CHAR_W-1:0] tx_data_q, tx_data_d, head;
  logic tx_valid_q, tx_valid_d;
  logic [GW-1:0] gap_q, gap_d;
  logic ie_q, ie_d, ovf_q, ovf_d, irq_q, irq_d;
  logic full, empty, push, pop, ready_nxt;
  logic [AW:0] count, count_nxt;
  logic unused;
  assign unused = ^{DATA[15], DATA[12:8]};
  assign push = LD_DDR & ~full;
  lc3_char_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (DATA[CHAR_W-1:0]),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  assign DSR      = {~full, ie_q, ovf_q, 13'b0};
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign irq      = irq_q;
  // status bits; a write to DDR while full wins over a same-cycle OVF clear so no drop goes unseen
  always_comb begin
    count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
    ready_nxt = count_nxt != (AW+1)'(DEPTH);
    ie_d      = LD_DSR ? DATA[IE_BIT] : ie_q;
    ovf_d     = (LD_DDR & full) | (ovf_q & ~(LD_DSR & DATA[OVF_BIT]));
    irq_d     = ie_d & ready_nxt;
  end
  // output FSM: pop into the holding register, wait for the sink, then enforce the gap
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    gap_d      = gap_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop        = 1'b1;
        tx_data_d  = head;
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end
      SEND: if (tx_ready) begin
        tx_valid_d = 1'b0;
        state_d    = CHAR_GAP == 0 ? IDLE : GAP;
        gap_d      = GW'(CHAR_GAP - 1);
      end
      GAP: begin
        gap_d   = gap_q == '0 ? gap_q : gap_q - 1'b1;
        state_d = gap_q == '0 ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      gap_q      <= '0;
      ie_q       <= 1'b0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      gap_q      <= gap_d;
      ie_q       <= ie_d;
      ovf_q      <= ovf_d;
      irq_q      <= irq_d;
    end
endmodule

// File: doc/lc3_display_ctrl.md
Name: lc3_display_ctrl

Overview:
- Display-side controller behind the LC-3 memory-mapped DSR/DDR pair.
- Buffers characters written to DDR in a small FIFO and drains them one at a time to a downstream screen/serial sink over a valid/ready handshake, with a programmable inter-character gap.
- Drives a real DSR: ready, interrupt enable and sticky overflow bits, plus a level interrupt request to the LC-3 interrupt logic.

Parameters:
- DEPTH, 4, FIFO depth in characters; power of 2, minimum 2.
- CHAR_GAP, 2, idle cycles enforced after each accepted character; 0 allowed.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- LD_DDR  input  1  DDR write strobe from the address decoder; one character per cycle high.
- LD_DSR  input  1  DSR write strobe.
- DATA  input  16  CPU write data.
- DSR  output  16  status register read value.
- tx_data  output  8  character to sink.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  sink accepts when tx_valid and tx_ready are high on the same edge.
- irq  output  1  display interrupt request, level.

Behaviour:
- Reset, asynchronous, active low: FIFO empty, read/write pointers and count 0, tx_valid=0, tx_data=0, IE=0, OVF=0, gap counter 0, FSM in IDLE, irq=0. DSR therefore reads 16'h8000.
- DSR map:
  - [15] READY = FIFO not full, from the registered count.
  - [14] IE.
  - [13] OVF.
  - [12:0] read 0.
- LD_DSR: IE<=DATA[14]. If DATA[13]=1, OVF is cleared (write-1-to-clear); otherwise OVF holds.
- LD_DDR and FIFO not full: push DATA[7:0]; count+1 next cycle. DATA[15:8] is ignored.
- LD_DDR and FIFO full: character dropped, OVF<=1. A pop in the same cycle does not rescue the push, because full is evaluated on pre-edge state.
- Push and pop in the same cycle, not full: count unchanged; both pointers advance and wrap modulo DEPTH.
- LD_DDR and LD_DSR both high: both take effect.
- irq registered: irq<=IE & READY, where READY is the next-state value. irq drops the cycle after the FIFO becomes full or IE is cleared.
- Output FSM:
  - IDLE: if FIFO non-empty, pop the head into tx_data, tx_valid<=1, go to SEND.
  - SEND: hold tx_data/tx_valid stable until tx_valid & tx_ready. On acceptance tx_valid<=0; if CHAR_GAP=0 go to IDLE, else load gap counter with CHAR_GAP-1 and go to GAP.
  - GAP: decrement each cycle; at 0 go to IDLE.
- Latency: LD_DDR at edge t with empty FIFO and FSM in IDLE gives count=1 after t, pop at t+1, tx_valid high after edge t+1.
- Throughput with tx_ready tied high: one character per CHAR_GAP+2 cycles.
- tx_data is never changed while tx_valid=1. tx_ready while tx_valid=0 is ignored.
- Reset mid-transfer: character in flight and FIFO contents are discarded; tx_valid falls asynchronously.

Decomposition:
- Package lc3_display_pkg:
  - FSM state enum (IDLE, SEND, GAP).
  - DSR bit index constants READY_BIT=15, IE_BIT=14, OVF_BIT=13.
  - Character width 8.
- One sub-module, lc3_char_fifo:
  - Synchronous single-clock FIFO, parameter DEPTH, asynchronous active-low reset.
  - Ports push/pop/din/dout/full/empty/count; dout shows the head combinationally.
- Top contains the DSR register, irq logic and output FSM.

Test Plan:
- Reset release, then idle 5 cycles -> DSR=16'h8000, tx_valid=0, irq=0.
- tx_ready=1, CHAR_GAP=2, write 8'h41 via LD_DDR at cycle 0 -> tx_valid high from cycle 2 with tx_data=8'h41, accepted; next char (8'h42, written at cycle 1) presented at cycle 6.
- tx_ready=0, DEPTH=4, write 6 chars 8'h30..8'h35 -> after 5 writes DSR[15]=0 (one char in SEND, 4 in FIFO); 6th write sets DSR[13]=1; raise tx_ready -> sink receives 8'h30..8'h34 in order, 8'h35 never.
- Write DSR with DATA=16'h4000 while FIFO not full -> irq=1 next cycle; fill FIFO -> irq=0 one cycle after full; drain one char -> irq=1.
- OVF set, write DSR with DATA=16'h6000 -> OVF=0, IE=1; write 16'h4000 with OVF set -> OVF stays 1.
- tx_ready=0 with char in SEND, pulse rst_n low mid-cycle -> tx_valid=0 immediately; after release DSR=16'h8000 and no character emitted.
